// File: rtl/stall_ctrl_pkg.sv
// ============================================================================
// Module  : stall_ctrl_pkg
// Brief   : Stall vector codes, EX sequencer state codes and the stall
//           priority encoder shared by the stall controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package stall_ctrl_pkg;

  // Stall vector bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
  localparam logic [5:0] c_STALL_NONE = 6'b000000;
  localparam logic [5:0] c_STALL_IF   = 6'b000011;
  localparam logic [5:0] c_STALL_ID   = 6'b000111;
  localparam logic [5:0] c_STALL_EX   = 6'b001111;
  localparam logic [5:0] c_STALL_MEM  = 6'b011111;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_BUSY = c_ST_BUSY,
    ST_DONE = c_ST_DONE
  } ex_state_e;

  // Deeper stages win; a lower request is completely hidden by a higher one.
  function automatic logic [5:0] stall_encode(input logic req_mem,
                                              input logic req_ex,
                                              input logic req_id,
                                              input logic req_if);
    logic [5:0] v;
    if (req_mem)     v = c_STALL_MEM;
    else if (req_ex) v = c_STALL_EX;
    else if (req_id) v = c_STALL_ID;
    else if (req_if) v = c_STALL_IF;
    else             v = c_STALL_NONE;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stall_ctrl_ex_seq.sv
// ============================================================================
// Module  : stall_ctrl_ex_seq
// Brief   : Multi-cycle EX sequencer (IDLE/BUSY/DONE FSM with down-counter)
//           producing the EX stall request and the final-cycle done flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_ctrl_ex_seq
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_multi_start,
  input  logic [CNT_W-1:0] ex_multi_cycles,
  input  logic             ex_cancel,
  input  logic             stallreq_mem,
  output logic             ex_stall,
  output logic             ex_done,
  output logic             ex_busy,
  output logic [CNT_W-1:0] ex_cnt
);

  localparam logic [CNT_W-1:0] c_ZERO = '0;
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_TWO  = CNT_W'(2);

  ex_state_e        r_state;
  ex_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_start_multi;
  logic             w_start_single;

  assign w_start_multi  = ex_multi_start && (ex_multi_cycles >= c_TWO);
  assign w_start_single = ex_multi_start && (ex_multi_cycles <= c_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= c_ZERO;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ex_stall    = 1'b0;
    ex_done     = 1'b0;
    if (ex_cancel) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = c_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ex_done = w_start_single;
          if (w_start_multi) begin
            ex_stall = 1'b1;
            // The issue cycle already counts as one stalled cycle.
            if (ex_multi_cycles == c_TWO) begin
              w_state_nxt = ST_DONE;
              w_cnt_nxt   = c_ZERO;
            end else begin
              w_state_nxt = ST_BUSY;
              w_cnt_nxt   = ex_multi_cycles - c_TWO;
            end
          end
        end
        ST_BUSY: begin
          ex_stall = 1'b1;
          if (r_cnt <= c_ONE) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = c_ZERO;
          end else begin
            w_cnt_nxt = r_cnt - c_ONE;
          end
        end
        ST_DONE: begin
          ex_done = 1'b1;
          // Result must survive until MEM can accept it.
          if (!stallreq_mem) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = c_ZERO;
        end
      endcase
    end
  end

  assign ex_busy = r_busy;
  assign ex_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: rtl/stall_ctrl.sv
// ============================================================================
// Module  : stall_ctrl
// Brief   : Pipeline stall controller; merges IF/ID/EX/MEM stall requests
//           into the 6-bit stall vector and sequences multi-cycle EX ops.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_mem,
  input  logic             ex_multi_start,
  input  logic [CNT_W-1:0] ex_multi_cycles,
  input  logic             ex_cancel,
  output logic [5:0]       stall,
  output logic             ex_busy,
  output logic             ex_done,
  output logic [CNT_W-1:0] ex_cnt
);

  logic w_ex_stall;
  logic w_ex_done;

  stall_ctrl_ex_seq #(
    .CNT_W (CNT_W)
  ) u_ex_seq (
    .clk             (clk),
    .rst             (rst),
    .ex_multi_start  (ex_multi_start),
    .ex_multi_cycles (ex_multi_cycles),
    .ex_cancel       (ex_cancel),
    .stallreq_mem    (stallreq_mem),
    .ex_stall        (w_ex_stall),
    .ex_done         (w_ex_done),
    .ex_busy         (ex_busy),
    .ex_cnt          (ex_cnt)
  );

  // While reset is held the pipeline must run free so its own registers clear.
  always_comb begin
    stall   = c_STALL_NONE;
    ex_done = 1'b0;
    if (!rst) begin
      stall   = stall_encode(stallreq_mem, w_ex_stall, stallreq_id, stallreq_if);
      ex_done = w_ex_done;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stall_ctrl.sv
// ============================================================================
// Module  : tb_stall_ctrl
// Brief   : Self-checking bench for stall_ctrl: priority table, multi-cycle
//           corner sequences and random traffic against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       stallreq_if;
  logic       stallreq_id;
  logic       stallreq_mem;
  logic       ex_multi_start;
  logic [5:0] ex_multi_cycles;
  logic       ex_cancel;
  logic [5:0] stall;
  logic       ex_busy;
  logic       ex_done;
  logic [5:0] ex_cnt;

  stall_ctrl #(.CNT_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if     (stallreq_if),
    .stallreq_id     (stallreq_id),
    .stallreq_mem    (stallreq_mem),
    .ex_multi_start  (ex_multi_start),
    .ex_multi_cycles (ex_multi_cycles),
    .ex_cancel       (ex_cancel),
    .stall           (stall),
    .ex_busy         (ex_busy),
    .ex_done         (ex_done),
    .ex_cnt          (ex_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Values sampled by the most recent step
  logic [5:0] s_stall;
  logic       s_done;
  logic       s_busy;
  logic [5:0] s_cnt;

  // Reference model: remaining BUSY cycles of the current op, and result-held flag
  int m_rem  = 0;
  bit m_held = 1'b0;

  typedef struct {
    bit         rq_if;
    bit         rq_id;
    bit         rq_mem;
    bit         start;
    int         n;
    bit         cancel;
    logic [5:0] exp_stall;
    bit         exp_done;
  } vec_t;

  vec_t tbl[10];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit rq_if, input bit rq_id, input bit rq_mem,
                        input bit st, input int n, input bit can);
    rst             = r;
    stallreq_if     = rq_if;
    stallreq_id     = rq_id;
    stallreq_mem    = rq_mem;
    ex_multi_start  = st;
    ex_multi_cycles = 6'(n);
    ex_cancel       = can;
  endtask

  task automatic step(input string tag);
    bit         idle;
    bit         e_ex;
    bit         e_done;
    logic [5:0] e_stall;
    int         n;
    @(negedge clk);
    n    = int'(ex_multi_cycles);
    idle = (m_rem == 0) && !m_held;
    e_ex   = !rst && !ex_cancel && ((m_rem > 0) || (idle && ex_multi_start && n >= 2));
    e_done = !rst && !ex_cancel && (m_held || (idle && ex_multi_start && n <= 1));
    if (rst)               e_stall = 6'b000000;
    else if (stallreq_mem) e_stall = 6'b011111;
    else if (e_ex)         e_stall = 6'b001111;
    else if (stallreq_id)  e_stall = 6'b000111;
    else if (stallreq_if)  e_stall = 6'b000011;
    else                   e_stall = 6'b000000;
    s_stall = stall;
    s_done  = ex_done;
    s_busy  = ex_busy;
    s_cnt   = ex_cnt;
    cmp({tag, ".stall"},   32'(s_stall), 32'(e_stall));
    cmp({tag, ".ex_done"}, 32'(s_done),  32'(e_done));
    cmp({tag, ".ex_busy"}, 32'(s_busy),  32'((m_rem > 0) || m_held));
    cmp({tag, ".ex_cnt"},  32'(s_cnt),   32'(m_rem));
    @(posedge clk);
    if (rst || ex_cancel) begin
      m_rem  = 0;
      m_held = 1'b0;
    end else if (m_rem > 0) begin
      m_rem  = m_rem - 1;
      m_held = (m_rem == 0);
    end else if (m_held) begin
      m_held = stallreq_mem;
    end else if (ex_multi_start && n >= 2) begin
      m_rem  = n - 2;
      m_held = (n == 2);
    end
    #1;
  endtask

  initial begin
    int stalled;
    int dones;

    // Reset with every request asserted
    set_in(1, 1, 1, 1, 1, 5, 0);
    step("rst0");
    step("rst1");
    cmp("rst.stall", 32'(s_stall), 32'h0);
    cmp("rst.busy",  32'(s_busy),  32'h0);
    cmp("rst.cnt",   32'(s_cnt),   32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("post_rst");
    cmp("post_rst.stall", 32'(s_stall), 32'h0);

    // Priority table, FSM kept in IDLE throughout
    tbl[0] = '{0, 0, 0, 0, 0, 0, 6'b000000, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 6'b000011, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 6'b000111, 0};
    tbl[3] = '{1, 1, 0, 0, 0, 0, 6'b000111, 0};
    tbl[4] = '{1, 1, 1, 0, 0, 0, 6'b011111, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 0, 6'b011111, 0};
    tbl[6] = '{1, 1, 0, 1, 1, 0, 6'b000111, 1};
    tbl[7] = '{0, 0, 0, 1, 0, 0, 6'b000000, 1};
    tbl[8] = '{1, 0, 0, 1, 5, 1, 6'b000011, 0};
    tbl[9] = '{0, 1, 1, 1, 0, 0, 6'b011111, 1};
    for (int i = 0; i < 10; i++) begin
      set_in(0, tbl[i].rq_if, tbl[i].rq_id, tbl[i].rq_mem, tbl[i].start, tbl[i].n, tbl[i].cancel);
      step("tbl");
      cmp($sformatf("tbl%0d.stall", i), 32'(s_stall), 32'(tbl[i].exp_stall));
      cmp($sformatf("tbl%0d.done", i),  32'(s_done),  32'(tbl[i].exp_done));
    end

    // DIV, N=34: 33 stalled cycles then one done cycle
    set_in(0, 0, 0, 0, 1, 34, 0);
    step("div");
    stalled = (s_stall == 6'b001111) ? 1 : 0;
    dones   = s_done ? 1 : 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 33; k++) begin
      step("div");
      if (k == 1)  cmp("div.cnt_first", 32'(s_cnt), 32'd32);
      if (k == 32) cmp("div.cnt_last",  32'(s_cnt), 32'd1);
      if (k == 33) begin
        cmp("div.done_final",  32'(s_done),  32'h1);
        cmp("div.stall_final", 32'(s_stall), 32'h0);
      end else begin
        if (s_stall == 6'b001111) stalled++;
        if (s_done) dones++;
      end
    end
    cmp("div.stall_cycles", 32'(stalled), 32'd33);
    cmp("div.early_done",   32'(dones),   32'd0);
    step("div_idle");
    cmp("div.idle_busy", 32'(s_busy), 32'h0);

    // N=2 with MEM holding the result for three cycles
    set_in(0, 0, 0, 0, 1, 2, 0);
    step("hold");
    cmp("hold.issue", 32'(s_stall), 32'b001111);
    set_in(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step("hold");
      cmp("hold.mem_stall", 32'(s_stall), 32'b011111);
      cmp("hold.mem_done",  32'(s_done),  32'h1);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("hold");
    cmp("hold.release_done", 32'(s_done), 32'h1);
    step("hold");
    cmp("hold.idle_busy", 32'(s_busy), 32'h0);
    cmp("hold.idle_done", 32'(s_done), 32'h0);

    // N=10 cancelled in its 4th cycle
    set_in(0, 0, 0, 0, 1, 10, 0);
    step("cancel");
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("cancel");
    step("cancel");
    set_in(0, 0, 0, 0, 0, 0, 1);
    step("cancel");
    cmp("cancel.stall", 32'(s_stall), 32'h0);
    cmp("cancel.done",  32'(s_done),  32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("cancel");
    cmp("cancel.busy", 32'(s_busy), 32'h0);
    cmp("cancel.cnt",  32'(s_cnt),  32'h0);
    cmp("cancel.no_done", 32'(s_done), 32'h0);

    // Single-cycle ops (N=1, N=0)
    for (int n = 1; n >= 0; n--) begin
      set_in(0, 0, 0, 0, 1, n, 0);
      step("single");
      cmp($sformatf("single%0d.stall", n), 32'(s_stall), 32'h0);
      cmp($sformatf("single%0d.done", n),  32'(s_done),  32'h1);
      set_in(0, 0, 0, 0, 0, 0, 0);
      step("single");
      cmp($sformatf("single%0d.busy", n), 32'(s_busy), 32'h0);
    end

    // Reset in the middle of a 20-cycle op
    set_in(0, 0, 0, 0, 1, 20, 0);
    step("midrst");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("midrst");
    set_in(1, 0, 0, 0, 0, 0, 0);
    step("midrst");
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("midrst");
    cmp("midrst.cnt",   32'(s_cnt),   32'h0);
    cmp("midrst.busy",  32'(s_busy),  32'h0);
    cmp("midrst.stall", 32'(s_stall), 32'h0);

    // Random traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      set_in(($urandom % 64) == 0,
             ($urandom % 4) == 0,
             ($urandom % 4) == 0,
             ($urandom % 4) == 0,
             ($urandom % 3) == 0,
             (($urandom % 8) == 0) ? int'($urandom % 64) : int'($urandom % 8),
             ($urandom % 20) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
